// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes, dmem waits, halt.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rf_we_ex,
    input  logic [4:0]       rf_wa_ex,
    input  logic             mem_re_ex,
    input  logic             rf_re0_id,
    input  logic             rf_re1_id,
    input  logic [4:0]       rf_ra0_id,
    input  logic [4:0]       rf_ra1_id,
    input  logic             br_taken_ex,
    input  logic             dmem_req_mem,
    input  logic             dmem_ack,
    input  logic             halt_wb,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             stall_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             commit_en,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt,
    output logic [CNT_W-1:0] perf_ldu_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);

    typedef enum logic [1:0] {RUN, MEMWAIT, HALT, ERR} state_t;
    typedef enum logic [2:0] {
        ACT_RST, ACT_HALT, ACT_WAIT, ACT_BR, ACT_LDU, ACT_GO, ACT_FROZEN
    } act_t;

    state_t             state;
    logic [WAIT_W-1:0]  wait_cnt;
    act_t               act;
    logic               ldu;
    logic               mwait;
    logic [4:0]         stall_vec;
    logic [2:0]         flush_vec;

    function automatic act_t run_act(input logic h, input logic mw, input logic br,
                                     input logic ld);
        if (h)       return ACT_HALT;
        else if (mw) return ACT_WAIT;
        else if (br) return ACT_BR;
        else if (ld) return ACT_LDU;
        else         return ACT_GO;
    endfunction

    always_comb begin
        ldu   = mem_re_ex && rf_we_ex && (rf_wa_ex != 5'd0) &&
                ((rf_re0_id && (rf_ra0_id == rf_wa_ex)) ||
                 (rf_re1_id && (rf_ra1_id == rf_wa_ex)));
        mwait = dmem_req_mem && !dmem_ack;
        act   = ACT_FROZEN;
        if (rst) begin
            act = ACT_RST;
        end else begin
            case (state)
                RUN:     act = run_act(halt_wb, mwait, br_taken_ex, ldu);
                // the ack cycle falls back to the normal RUN priority with mwait already 0
                MEMWAIT: act = dmem_ack ? run_act(halt_wb, 1'b0, br_taken_ex, ldu) : ACT_WAIT;
                default: act = ACT_FROZEN;
            endcase
        end
    end

    always_comb begin
        stall_vec = 5'b00000;
        flush_vec = 3'b000;
        commit_en = 1'b0;
        case (act)
            ACT_RST:    flush_vec = 3'b111;
            ACT_HALT: begin
                stall_vec = 5'b11111;
                commit_en = 1'b1;
            end
            ACT_WAIT: begin
                stall_vec = 5'b11111;
                commit_en = (state == RUN);
            end
            ACT_BR: begin
                flush_vec = 3'b110;
                commit_en = 1'b1;
            end
            ACT_LDU: begin
                stall_vec = 5'b11000;
                flush_vec = 3'b010;
                commit_en = 1'b1;
            end
            ACT_GO:     commit_en = 1'b1;
            default:    stall_vec = 5'b11111;
        endcase
    end

    assign {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb} = stall_vec;
    assign {flush_if_id, flush_id_ex, flush_ex_mem} = flush_vec;
    assign halted = !rst && (state == HALT);
    assign err    = !rst && (state == ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (act)
                ACT_HALT: state <= HALT;
                ACT_WAIT: begin
                    if (state == RUN) begin
                        state    <= MEMWAIT;
                        wait_cnt <= WAIT_W'(1);
                    end else if ((MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT))) begin
                        state <= ERR;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ACT_BR, ACT_LDU, ACT_GO: state <= RUN;
                default: state <= state;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] ldu_cnt_q;
    logic             stall_any;

    assign stall_any = (|stall_vec) && ((state == RUN) || (state == MEMWAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            ldu_cnt_q   <= '0;
        end else begin
            if (stall_any && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if ((act == ACT_BR) && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            if ((act == ACT_LDU) && (ldu_cnt_q != '1))
                ldu_cnt_q <= ldu_cnt_q + CNT_W'(1);
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
    assign perf_ldu_cnt   = ldu_cnt_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
    assign perf_ldu_cnt   = '0;
`endif

endmodule
